// File: rtl/vsim_receive.sv
// rtl/vsim_receive.sv - host-to-hardware beat receive endpoint: DPI poll, beat FIFO, first/last framing
// VSIM_RECEIVE_STATS_EN adds beat_count/msg_count.
package vsim_receive_host_pkg;
    longint      host_q[$];
    int unsigned call_count;

    function automatic longint dpi_msgReceive_beat();
        longint rsp;
        call_count++;
        rsp = 64'd0;
        if (host_q.size() != 0) rsp = host_q.pop_front();
        return rsp;
    endfunction
endpackage

module vsim_receive #(
    parameter int width         = 32,
    parameter int DEPTH         = 4,
    parameter int POLL_INTERVAL = 1
) (
    input  logic             CLK,
    input  logic             nRST,
    output logic             EN_beat,
    input  logic             RDY_beat,
    output logic [width-1:0] beat,
    output logic             first,
    output logic             last
`ifdef VSIM_RECEIVE_STATS_EN
    ,
    output logic [31:0]      beat_count,
    output logic [31:0]      msg_count
`endif
);
    import vsim_receive_host_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam int EW = width + 2;

    typedef enum logic {IDLE = 1'b0, IN_MSG = 1'b1} state_t;

    // Slot layout {valid, last, data}: the poll writes the raw reply into the free slot
    // and the valid bit is folded into count/wr_ptr combinationally during the next cycle.
    function automatic logic [EW-1:0] host_entry();
        logic [63:0] rsp;
        rsp = dpi_msgReceive_beat();
        return {rsp[32], rsp[33], rsp[width-1:0]};
    endfunction

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] head;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d, count_eff;
    logic [TW-1:0] timer_q, timer_d, timer_eff;
    logic          polled_q, polled_d;
    logic          pend_push, pop, full, poll;
    state_t        state_q, state_d;

    always_comb begin
        head      = mem_q[rd_ptr_q];
        pend_push = polled_q && mem_q[wr_ptr_q][EW-1];
        wr_ptr_d  = wr_ptr_q + AW'(pend_push);
        count_eff = count_q + CW'(pend_push);
        timer_eff = timer_q;
        if (polled_q) timer_eff = pend_push ? '0 : TW'(POLL_INTERVAL - 1);

        full     = (count_eff == CW'(DEPTH));
        EN_beat  = (count_eff != '0);
        pop      = EN_beat && RDY_beat;
        poll     = !full && (timer_eff == '0);
        polled_d = poll;
        count_d  = count_eff - CW'(pop);
        rd_ptr_d = rd_ptr_q + AW'(pop);

        timer_d = timer_eff;
        if (!poll && !full && (timer_eff != '0)) timer_d = timer_eff - TW'(1);

        state_d = state_q;
        if (pop) state_d = head[width] ? IDLE : IN_MSG;

        beat  = head[width-1:0];
        last  = head[width];
        first = (state_q == IDLE);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            timer_q  <= '0;
            polled_q <= 1'b0;
            state_q  <= IDLE;
        end else begin
            if (poll) mem_q[wr_ptr_d] <= host_entry();
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            timer_q  <= timer_d;
            polled_q <= polled_d;
            state_q  <= state_d;
        end
    end

`ifdef VSIM_RECEIVE_STATS_EN
    logic [31:0] beat_count_q, beat_count_d, msg_count_q, msg_count_d;

    always_comb begin
        beat_count_d = beat_count_q + 32'(pop);
        msg_count_d  = msg_count_q + 32'(pop && head[width]);
        beat_count   = beat_count_q;
        msg_count    = msg_count_q;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            beat_count_q <= '0;
            msg_count_q  <= '0;
        end else begin
            beat_count_q <= beat_count_d;
            msg_count_q  <= msg_count_d;
            if (pop) $display("VSINK: beat %x last %x", beat, last);
        end
    end
`endif
endmodule

// File: tb/tb_vsim_receive.sv
// tb/tb_vsim_receive.sv - scoreboard bench for vsim_receive driving the SV host queue
module tb_vsim_receive;
    import vsim_receive_host_pkg::*;

    typedef struct {
        logic [31:0] data;
        bit          first;
        bit          last;
    } exp_t;

    logic        CLK = 1'b0;
    logic        rst0, rst1, rst2, rdy0, rdy1, rdy2;
    logic        en0, en1, en2, first0, first1, first2, last0, last1, last2;
    logic [31:0] beat0, beat1;
    logic [7:0]  beat2;
`ifdef VSIM_RECEIVE_STATS_EN
    logic [31:0] bc0, mc0, bc1, mc1, bc2, mc2;
`endif

    exp_t exp0[$], exp1[$], exp2[$];
    bit   in_msg;
    int   n_checks, n_fail;

    always #5 CLK = ~CLK;

    vsim_receive u0 (.CLK(CLK), .nRST(rst0), .EN_beat(en0), .RDY_beat(rdy0), .beat(beat0),
                     .first(first0), .last(last0)
`ifdef VSIM_RECEIVE_STATS_EN
                     , .beat_count(bc0), .msg_count(mc0)
`endif
                     );
    vsim_receive #(.POLL_INTERVAL(4)) u1 (.CLK(CLK), .nRST(rst1), .EN_beat(en1), .RDY_beat(rdy1),
                     .beat(beat1), .first(first1), .last(last1)
`ifdef VSIM_RECEIVE_STATS_EN
                     , .beat_count(bc1), .msg_count(mc1)
`endif
                     );
    vsim_receive #(.width(8)) u2 (.CLK(CLK), .nRST(rst2), .EN_beat(en2), .RDY_beat(rdy2),
                     .beat(beat2), .first(first2), .last(last2)
`ifdef VSIM_RECEIVE_STATS_EN
                     , .beat_count(bc2), .msg_count(mc2)
`endif
                     );

    task automatic chk(string name, longint act, longint req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Host side: one beat into the host queue, its expected delivery into the instance's scoreboard.
    task automatic queue_beat(int k, logic [31:0] d, bit l);
        logic [63:0] w;
        exp_t        e;
        w       = {$urandom(), d};
        w[32]   = 1'b1;
        w[33]   = l;
        host_q.push_back(longint'(w));
        e.data  = (k == 2) ? (d & 32'hFF) : d;
        e.first = !in_msg;
        e.last  = l;
        in_msg  = !l;
        if (k == 0) exp0.push_back(e);
        else if (k == 1) exp1.push_back(e);
        else exp2.push_back(e);
    endtask

    task automatic mon(int k, logic [31:0] b, bit f, bit l);
        exp_t e;
        int   sz;
        sz = (k == 0) ? exp0.size() : (k == 1) ? exp1.size() : exp2.size();
        if (sz == 0) begin
            chk($sformatf("u%0d unexpected beat %0h", k, b), 1, 0);
            return;
        end
        if (k == 0) e = exp0.pop_front();
        else if (k == 1) e = exp1.pop_front();
        else e = exp2.pop_front();
        chk($sformatf("u%0d beat", k), b, e.data);
        chk($sformatf("u%0d first", k), f, e.first);
        chk($sformatf("u%0d last", k), l, e.last);
    endtask

    always @(negedge CLK) begin
        if (rst0 && en0 && rdy0) mon(0, beat0, first0, last0);
        if (rst1 && en1 && rdy1) mon(1, beat1, first1, last1);
        if (rst2 && en2 && rdy2) mon(2, {24'b0, beat2}, first2, last2);
    end

    task automatic drain(int k, int budget);
        int left;
        left = budget;
        while (left > 0 && ((k == 0) ? exp0.size() : (k == 1) ? exp1.size() : exp2.size()) != 0) begin
            tick();
            left--;
        end
        chk($sformatf("u%0d drained", k), (k == 0) ? exp0.size() : (k == 1) ? exp1.size() : exp2.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cc, ncalls, lastpoll, lat;
`ifdef VSIM_RECEIVE_STATS_EN
        int bsnap, msnap;
`endif
        n_checks = 0; n_fail = 0; in_msg = 0;
        rst0 = 0; rst1 = 0; rst2 = 0; rdy0 = 0; rdy1 = 0; rdy2 = 0;
        #2;
        chk("reset en0", en0, 0);
        chk("reset first0", first0, 1);
        chk("reset en1", en1, 0);
        chk("reset en2", en2, 0);
        chk("no calls in reset", call_count, 0);
        tick();
        rst0 = 1; rdy0 = 1;
        repeat (3) tick();

        // single beat, latency one edge
        queue_beat(0, 32'h12345678, 1'b1);
        cc = int'(call_count);
        chk("single en before", en0, 0);
        tick();
        chk("single call", int'(call_count) - cc, 1);
        chk("single en after", en0, 1);
        chk("single first", first0, 1);
        chk("single last", last0, 1);
        tick();
        chk("single en gone", en0, 0);

        // three-beat message
`ifdef VSIM_RECEIVE_STATS_EN
        bsnap = int'(bc0); msnap = int'(mc0);
`endif
        queue_beat(0, 32'hA, 1'b0);
        queue_beat(0, 32'hB, 1'b0);
        queue_beat(0, 32'hC, 1'b1);
        drain(0, 20);
        tick();
`ifdef VSIM_RECEIVE_STATS_EN
        chk("stats beats", int'(bc0) - bsnap, 3);
        chk("stats msgs", int'(mc0) - msnap, 1);
`endif

        // backpressure and full
        rdy0 = 0;
        tick();
        cc = int'(call_count);
        for (int i = 0; i < 6; i++) queue_beat(0, 32'h100 + i, i == 5);
        repeat (8) tick();
        chk("full valid calls", int'(call_count) - cc, 4);
        chk("full host left", host_q.size(), 2);
        chk("full en", en0, 1);
        cc = int'(call_count);
        rdy0 = 1;
        tick();
        rdy0 = 0;
        chk("no poll on full pop", int'(call_count) - cc, 0);
        tick();
        chk("refill poll", int'(call_count) - cc, 1);
        chk("refill host left", host_q.size(), 1);
        rdy0 = 1;
        drain(0, 30);

        // randomized traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            rdy0 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) queue_beat(0, $urandom(), $urandom_range(0, 3) == 0);
            tick();
        end
        queue_beat(0, $urandom(), 1'b1);
        rdy0 = 1;
        drain(0, 400);

        // reset in the middle of a message
        rdy0 = 0;
        queue_beat(0, 32'hD0, 1'b0);
        queue_beat(0, 32'hD1, 1'b0);
        queue_beat(0, 32'hD2, 1'b0);
        repeat (6) tick();
        rdy0 = 1;
        tick();
        rdy0 = 0;
        chk("mid host empty", host_q.size(), 0);
        chk("mid first0", first0, 0);
        tick();
        rst0 = 0;
        #1;
        chk("async reset en", en0, 0);
        chk("async reset first", first0, 1);
        cc = int'(call_count);
        tick();
        tick();
        chk("no call during reset", int'(call_count) - cc, 0);
        exp0.delete();
        in_msg = 0;
        rst0 = 1;
        rdy0 = 1;
        queue_beat(0, 32'hE0, 1'b1);
        drain(0, 10);

        // poll throttle, POLL_INTERVAL=4
        rst0 = 0;
        tick();
        rst1 = 1; rdy1 = 1;
        cc = int'(call_count); ncalls = 0; lastpoll = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (int'(call_count) != cc) begin
                if (ncalls > 0) chk("poll gap", i - lastpoll, 4);
                ncalls++;
                lastpoll = i;
                cc = int'(call_count);
            end
        end
        chk("poll count", ncalls, 5);
        queue_beat(1, 32'h51, 1'b0);
        queue_beat(1, 32'h52, 1'b0);
        queue_beat(1, 32'h53, 1'b1);
        lat = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (en1 && lat == 0) lat = i;
            if (lat != 0) break;
        end
        chk("throttle latency ok", (lat >= 1 && lat <= 4), 1);
        cc = int'(call_count);
        tick();
        tick();
        chk("back to back polls", int'(call_count) - cc, 2);
        chk("throttle host empty", host_q.size(), 0);
        drain(1, 10);

        // width=8 truncation
        rst1 = 0;
        tick();
        rst2 = 1; rdy2 = 1;
        queue_beat(2, 32'h1FF, 1'b1);
        lat = 0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (en2 && lat == 0) lat = i;
            if (lat != 0) break;
        end
        chk("w8 latency", lat, 1);
        drain(2, 10);

        chk("u0 leftovers", exp0.size(), 0);
        chk("u1 leftovers", exp1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vsim_receive.md
Name: vsim_receive

Overview:
- Simulation-only receive endpoint for the host↔hardware message channel: the opposite direction of the DPI beat sender.
- Polls the host through DPI for inbound message beats and buffers them in a small FIFO.
- Presents beats to the hardware consumer over an EN/RDY method handshake, with first/last framing.
- Sits at the top of the simulation harness, feeding the request-side demux.

Parameters:
- width, 32, beat data width in bits; legal range 1..32; lower `width` bits of the DPI data word are used.
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- POLL_INTERVAL, 1, cycles between DPI polls after an empty poll; 1 means poll every cycle.

Ports:
- CLK  input  1  clock
- nRST  input  1  asynchronous active-low reset
- EN_beat  output  1  beat valid to consumer
- RDY_beat  input  1  consumer ready; transfer when EN_beat && RDY_beat
- beat  output  width  beat data (FIFO head)
- first  output  1  head beat is the first beat of a message
- last  output  1  head beat is the last beat of a message

Behaviour:
- DPI import: function `longint dpi_msgReceive_beat()`.
  - Return bit 32 = valid, bit 33 = last, bits 31:0 = data.
  - All other bits are ignored.
- Reset (nRST low, asynchronous):
  - EN_beat=0; FIFO empties (count=0, rd_ptr=wr_ptr=0).
  - Poll timer = 0; frame state = IDLE.
  - No DPI call while nRST is low.
  - Beats already fetched into the FIFO are discarded (lost); the host is not notified.
- Poll:
  - On a posedge with nRST high, count < DEPTH (count sampled before this edge's pop) and poll timer == 0: call the DPI function exactly once.
  - If valid: push {last, data[width-1:0]} and set timer = 0.
  - If not valid: no push; timer = POLL_INTERVAL-1.
  - Timer decrements by 1 per cycle when nonzero, saturating at 0.
  - Timer does not decrement while the FIFO is full.
- FIFO:
  - Circular buffer with log2(DEPTH)-bit pointers that wrap naturally.
  - Separate count register, 0..DEPTH.
  - Outputs are driven combinationally from the head entry.
  - EN_beat = (count != 0). beat and last are don't-care when EN_beat=0 but must not be X after reset.
- Latency: a beat returned by the DPI call at edge N is visible with EN_beat=1 in the cycle after edge N. There is no same-cycle bypass.
- Pop: on a posedge with EN_beat && RDY_beat, advance rd_ptr.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full (count == DEPTH): no DPI call that edge, even if a pop occurs on the same edge. The freed slot is polled on the next edge.
- Empty: RDY_beat is ignored; no pointer movement.
- Framing FSM (advances only on a pop):
  - IDLE → IN_MSG when a popped beat has last=0.
  - IN_MSG → IDLE when a popped beat has last=1.
  - first = (state == IDLE).
  - A single-beat message (last=1 while IDLE) stays in IDLE.
- Consumer protocol: RDY_beat may toggle freely. Head data is stable while EN_beat=1 and no pop occurs.

Optional Feature:
- Macro: VSIM_RECEIVE_STATS_EN.
- With the macro defined, two outputs are added:
  - beat_count (32b): total beats popped.
  - msg_count (32b): total pops with last=1.
  - Both reset to 0, wrap modulo 2^32, and increment on the pop edge.
  - On every pop: `$display("VSINK: beat %x last %x", beat, last)`.
- Without the macro: no extra ports, registers or display; behaviour otherwise identical.

Test Plan:
- Single beat: host queues one beat {data=0x12345678, last=1}; RDY_beat=1.
  - Expect EN_beat=1 exactly one cycle after the DPI call, beat=0x12345678, first=1, last=1, then EN_beat=0.
- Multi-beat message: host queues 3 beats 0xA,0xB,0xC with last on 0xC; RDY_beat=1.
  - Expect first=1,0,0 and last=0,0,1 on the three pops.
  - With stats enabled: msg_count=1, beat_count=3.
- Backpressure/full: DEPTH=4, RDY_beat=0, host queues 6 beats.
  - Expect exactly 4 DPI valid returns, then no DPI calls while full.
  - Raise RDY_beat for 1 cycle: one pop, no poll that edge, poll on the next edge refills count to 4.
  - Order is preserved across pointer wrap, all 6 beats delivered in order.
- Poll throttle: POLL_INTERVAL=4, host queue empty for 20 cycles.
  - Expect DPI calls every 4th cycle.
  - Host queues a beat: delivered within 4 cycles; afterwards polls are back-to-back while beats remain.
- Reset mid-message: 2 beats buffered, state IN_MSG; pulse nRST low between edges.
  - Expect EN_beat=0 immediately (asynchronous), count=0, first=1 on the next beat received, no DPI call during reset.
- width=8: host sends data 0x1FF.
  - Expect beat=0xFF and a normal handshake.
